// File: rtl/writeback.sv
// writeback: commit stage downstream of execute.
// Serializes up to two operand writes (opnd0 then opnd1) onto one register-file
// write port and one valid/ready memory write port. It also owns the
// architectural EFLAGS register, which is updated only on the retire cycle.
//
// Optional feature: define WRITEBACK_RETIRE_COUNT_EN to build the retired-
// instruction counter. When it is undefined, retire_count is tied to zero.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   execute-result handshake (ready only while idle)
//   opnd0_w/opnd1_w     result data for destinations 0 and 1
//   exe_eflags/flags_we prospective EFLAGS and its commit enable
//   dst*_kind/reg/addr  destination descriptors (0 none, 1 reg, 2 mem, 3 reserved)
//   opnd_size           0 = 8-bit, 1 = 16-bit, 2/3 = 32-bit
//   rf_*                register-file write port
//   mem_*               memory write port (mem_wvalid/mem_wready handshake)
//   eflags_q            architectural EFLAGS
//   retire              one-cycle commit pulse
//   wb_err              sticky flag: reserved destination kind seen
//   retire_count        retired-instruction count (zero unless feature built)
module writeback #(
    parameter logic [31:0] EFLAGS_RESET = 32'h0000_0002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] opnd0_w,
    input  logic [31:0] opnd1_w,
    input  logic [31:0] exe_eflags,
    input  logic        flags_we,
    input  logic [1:0]  dst0_kind,
    input  logic [1:0]  dst1_kind,
    input  logic [2:0]  dst0_reg,
    input  logic [2:0]  dst1_reg,
    input  logic [31:0] dst0_addr,
    input  logic [31:0] dst1_addr,
    input  logic [1:0]  opnd_size,
    output logic        rf_we,
    output logic [2:0]  rf_idx,
    output logic [31:0] rf_data,
    output logic [3:0]  rf_bmask,
    output logic        mem_wvalid,
    input  logic        mem_wready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic [31:0] eflags_q,
    output logic        retire,
    output logic        wb_err,
    output logic [31:0] retire_count
);

    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_REG  = 2'd1;
    localparam logic [1:0] KIND_MEM  = 2'd2;
    localparam logic [1:0] KIND_RSVD = 2'd3;

    typedef enum logic [1:0] {IDLE, WB0, WB1, RETIRE} state_t;

    state_t state, state_nx;

    logic [31:0] d0_q, d1_q, a0_q, a1_q, efl_q;
    logic [1:0]  k0_q, k1_q, size_q;
    logic [2:0]  r0_q, r1_q;
    logic        fwe_q;

    logic [1:0]  slot_kind;
    logic [2:0]  slot_reg;
    logic [31:0] slot_data;
    logic [31:0] slot_addr;
    logic        slot_done;

    function automatic logic slot_active(input logic [1:0] kind);
        return (kind == KIND_REG) || (kind == KIND_MEM);
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Current write slot: descriptor of the destination being committed
    always_comb begin
        slot_kind = KIND_NONE;
        slot_reg  = 3'd0;
        slot_data = 32'd0;
        slot_addr = 32'd0;
        if (state == WB0) begin
            slot_kind = k0_q;
            slot_reg  = r0_q;
            slot_data = d0_q;
            slot_addr = a0_q;
        end else if (state == WB1) begin
            slot_kind = k1_q;
            slot_reg  = r1_q;
            slot_data = d1_q;
            slot_addr = a1_q;
        end
        // A memory slot waits for the handshake; a register slot takes one cycle
        slot_done = (slot_kind != KIND_MEM) || mem_wready;
    end

    // Next-state logic; inactive slots are skipped outright
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (slot_active(dst0_kind))      state_nx = WB0;
                    else if (slot_active(dst1_kind)) state_nx = WB1;
                    else                             state_nx = RETIRE;
                end
            end
            WB0: begin
                if (slot_done) state_nx = slot_active(k1_q) ? WB1 : RETIRE;
            end
            WB1: begin
                if (slot_done) state_nx = RETIRE;
            end
            RETIRE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from state and latched operands
    always_comb begin
        in_ready   = 1'b0;
        retire     = 1'b0;
        rf_we      = 1'b0;
        rf_idx     = 3'd0;
        rf_data    = 32'd0;
        rf_bmask   = 4'd0;
        mem_wvalid = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        mem_wmask  = 4'd0;
        if (state == IDLE)   in_ready = 1'b1;
        if (state == RETIRE) retire   = 1'b1;
        if (slot_kind == KIND_REG) begin
            rf_we = 1'b1;
            // 8-bit writes to indices 4-7 target the high byte of regs 0-3
            if (size_q == 2'd0 && slot_reg[2]) begin
                rf_idx   = {1'b0, slot_reg[1:0]};
                rf_bmask = 4'b0010;
                rf_data  = {16'd0, slot_data[7:0], 8'd0};
            end else begin
                rf_idx   = slot_reg;
                rf_bmask = size_mask(size_q);
                rf_data  = slot_data;
            end
        end
        if (slot_kind == KIND_MEM) begin
            mem_wvalid = 1'b1;
            mem_addr   = slot_addr;
            mem_wdata  = slot_data;
            mem_wmask  = size_mask(size_q);
        end
    end

    // Operand latch, sticky error flag and architectural EFLAGS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0_q     <= 32'd0;
            d1_q     <= 32'd0;
            a0_q     <= 32'd0;
            a1_q     <= 32'd0;
            efl_q    <= 32'd0;
            k0_q     <= KIND_NONE;
            k1_q     <= KIND_NONE;
            size_q   <= 2'd0;
            r0_q     <= 3'd0;
            r1_q     <= 3'd0;
            fwe_q    <= 1'b0;
            wb_err   <= 1'b0;
            eflags_q <= EFLAGS_RESET;
        end else begin
            if (state == IDLE && in_valid) begin
                d0_q   <= opnd0_w;
                d1_q   <= opnd1_w;
                a0_q   <= dst0_addr;
                a1_q   <= dst1_addr;
                efl_q  <= exe_eflags;
                k0_q   <= dst0_kind;
                k1_q   <= dst1_kind;
                size_q <= opnd_size;
                r0_q   <= dst0_reg;
                r1_q   <= dst1_reg;
                fwe_q  <= flags_we;
                if (dst0_kind == KIND_RSVD || dst1_kind == KIND_RSVD) wb_err <= 1'b1;
            end
            // Flags become visible only once the whole instruction has committed
            if (state == RETIRE && fwe_q) eflags_q <= efl_q | 32'h0000_0002;
        end
    end

`ifdef WRITEBACK_RETIRE_COUNT_EN
    logic [31:0] retire_cnt_q;

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  retire_cnt_q <= 32'd0;
        else if (state == RETIRE) retire_cnt_q <= retire_cnt_q + 32'd1;
    end

    assign retire_count = retire_cnt_q;
`else
    assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] opnd0_w = '0, opnd1_w = '0, exe_eflags = '0;
    logic        flags_we = 1'b0;
    logic [1:0]  dst0_kind = '0, dst1_kind = '0, opnd_size = '0;
    logic [2:0]  dst0_reg = '0, dst1_reg = '0;
    logic [31:0] dst0_addr = '0, dst1_addr = '0;
    logic        rf_we;
    logic [2:0]  rf_idx;
    logic [31:0] rf_data;
    logic [3:0]  rf_bmask;
    logic        mem_wvalid;
    logic        mem_wready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] eflags_q;
    logic        retire;
    logic        wb_err;
    logic [31:0] retire_count;

    always #5 clk = ~clk;

    writeback dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opnd0_w(opnd0_w), .opnd1_w(opnd1_w), .exe_eflags(exe_eflags),
        .flags_we(flags_we), .dst0_kind(dst0_kind), .dst1_kind(dst1_kind),
        .dst0_reg(dst0_reg), .dst1_reg(dst1_reg), .dst0_addr(dst0_addr),
        .dst1_addr(dst1_addr), .opnd_size(opnd_size), .rf_we(rf_we),
        .rf_idx(rf_idx), .rf_data(rf_data), .rf_bmask(rf_bmask),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .eflags_q(eflags_q),
        .retire(retire), .wb_err(wb_err), .retire_count(retire_count)
    );

    typedef struct {
        logic [1:0]  k0, k1, size;
        logic [2:0]  r0, r1;
        logic [31:0] a0, a1, d0, d1, efl;
        logic        fwe;
    } txn_t;

    typedef struct { logic [2:0] idx; logic [31:0] data; logic [3:0] mask; } rf_exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] mask; } mem_exp_t;

    rf_exp_t     rf_q[$];
    mem_exp_t    mem_q[$];
    logic [31:0] ret_q[$];

    int          total = 0;
    int          bad = 0;
    logic [31:0] model_eflags = 32'h2;
    logic        exp_err = 1'b0;
    logic [31:0] exp_cnt = 32'd0;
    logic [31:0] efl_exp = 32'd0;
    bit          chk_efl = 1'b0;
    bit          rand_ready = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=unexpected required=none", name);
    endtask

    // Reference model: the byte-lane rules applied to one destination
    task automatic model_slot(input logic [1:0] kind, input logic [2:0] r, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] size);
        rf_exp_t  re;
        mem_exp_t me;
        logic [3:0] m;
        m = (size == 2'd0) ? 4'h1 : (size == 2'd1) ? 4'h3 : 4'hF;
        if (kind == 2'd1) begin
            if (size == 2'd0 && r >= 3'd4) begin
                re.idx = r - 3'd4; re.mask = 4'h2; re.data = (d & 32'hFF) << 8;
            end else begin
                re.idx = r; re.mask = m; re.data = d;
            end
            rf_q.push_back(re);
        end else if (kind == 2'd2) begin
            me.addr = a; me.data = d; me.mask = m;
            mem_q.push_back(me);
        end
    endtask

    // Driver: wait for ready, present a result, queue the expected effects
    task automatic send(input txn_t t);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        opnd0_w = t.d0; opnd1_w = t.d1; exe_eflags = t.efl; flags_we = t.fwe;
        dst0_kind = t.k0; dst1_kind = t.k1; dst0_reg = t.r0; dst1_reg = t.r1;
        dst0_addr = t.a0; dst1_addr = t.a1; opnd_size = t.size;
        in_valid = 1'b1;
        model_slot(t.k0, t.r0, t.a0, t.d0, t.size);
        model_slot(t.k1, t.r1, t.a1, t.d1, t.size);
        if (t.fwe) model_eflags = t.efl | 32'h2;
        ret_q.push_back(model_eflags);
        @(posedge clk);
        if (t.k0 == 2'd3 || t.k1 == 2'd3) exp_err = 1'b1;
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rf_q.size() != 0 || mem_q.size() != 0 || ret_q.size() != 0 || !in_ready) && n < 2000) begin
            @(negedge clk); n++;
        end
        if (n >= 2000) check("drain_timeout", 32'(ret_q.size()), 32'd0);
        @(negedge clk);
    endtask

    function automatic txn_t blank();
        txn_t t;
        t.k0 = 2'd0; t.k1 = 2'd0; t.size = 2'd2; t.r0 = 3'd0; t.r1 = 3'd0;
        t.a0 = 32'd0; t.a1 = 32'd0; t.d0 = 32'd0; t.d1 = 32'd0; t.efl = 32'd0; t.fwe = 1'b0;
        return t;
    endfunction

    always @(negedge clk) if (rand_ready) mem_wready = 1'($urandom_range(0, 1));

    // Monitor: compare every presented output against the scoreboard
    always begin
        rf_exp_t  re;
        mem_exp_t me;
        @(negedge clk);
        #1;
        if (rst) begin
            rf_q.delete(); mem_q.delete(); ret_q.delete(); chk_efl = 1'b0;
        end else begin
            check("wb_err", 32'(wb_err), 32'(exp_err));
            check("retire_count", retire_count, exp_cnt);
            if (chk_efl) begin
                check("eflags", eflags_q, efl_exp);
                chk_efl = 1'b0;
            end
            if (rf_we) begin
                if (rf_q.size() == 0) fail_now("rf_unexpected");
                else begin
                    re = rf_q.pop_front();
                    check("rf_idx", 32'(rf_idx), 32'(re.idx));
                    check("rf_data", rf_data, re.data);
                    check("rf_bmask", 32'(rf_bmask), 32'(re.mask));
                end
            end
            if (mem_wvalid) begin
                if (mem_q.size() == 0) fail_now("mem_unexpected");
                else begin
                    me = mem_q[0];
                    check("mem_addr", mem_addr, me.addr);
                    check("mem_wdata", mem_wdata, me.data);
                    check("mem_wmask", 32'(mem_wmask), 32'(me.mask));
                    if (mem_wready) void'(mem_q.pop_front());
                end
            end
            if (retire) begin
                if (ret_q.size() == 0) fail_now("retire_unexpected");
                else begin
                    if (rf_q.size() != 0 || mem_q.size() != 0) fail_now("retire_before_writes");
                    efl_exp = ret_q.pop_front();
                    chk_efl = 1'b1;
`ifdef WRITEBACK_RETIRE_COUNT_EN
                    exp_cnt = exp_cnt + 32'd1;
`endif
                end
            end
        end
    end

    initial begin
        txn_t t;
        // Reset values
        repeat (2) @(negedge clk);
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_mem_wvalid", 32'(mem_wvalid), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_wb_err", 32'(wb_err), 32'd0);
        check("rst_eflags", eflags_q, 32'h2);
        check("rst_retire_count", retire_count, 32'd0);
        check("rst_outs", rf_data | mem_addr | mem_wdata | 32'(rf_idx) | 32'(rf_bmask) | 32'(mem_wmask), 32'd0);
        rst = 1'b0;

        // Register/register commit with flags
        t = blank(); t.k0 = 2'd1; t.r0 = 3'd0; t.k1 = 2'd1; t.r1 = 3'd3;
        t.d0 = 32'h1111_1111; t.d1 = 32'h2222_2222; t.fwe = 1'b1; t.efl = 32'h0000_0845;
        send(t);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); #2;
            check("rr_rf_we", 32'(rf_we), 32'(i <= 2));
            check("rr_retire", 32'(retire), 32'(i == 3));
            check("rr_in_ready", 32'(in_ready), 32'(i == 4));
            if (i == 4) check("rr_eflags", eflags_q, 32'h0000_0847);
        end

        // High-byte register write
        t = blank(); t.k0 = 2'd1; t.r0 = 3'd4; t.size = 2'd0; t.d0 = 32'h0000_00AB;
        send(t);
        @(negedge clk); #2;
        check("hb_rf_idx", 32'(rf_idx), 32'd0);
        check("hb_rf_bmask", 32'(rf_bmask), 32'h2);
        check("hb_rf_data", rf_data, 32'h0000_AB00);
        drain();

        // Memory backpressure
        rand_ready = 1'b0; mem_wready = 1'b0;
        t = blank(); t.k0 = 2'd2; t.a0 = 32'h0000_1000; t.size = 2'd1; t.d0 = 32'h0000_BEEF;
        send(t);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 4) mem_wready = 1'b1;
            #2;
            check("bp_wvalid", 32'(mem_wvalid), 32'd1);
            check("bp_addr", mem_addr, 32'h0000_1000);
            check("bp_data", mem_wdata, 32'h0000_BEEF);
            check("bp_mask", 32'(mem_wmask), 32'h3);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_retire", 32'(retire), 32'd0);
        end
        @(negedge clk); mem_wready = 1'b0; #2;
        check("bp_retire_after", 32'(retire), 32'd1);
        check("bp_wvalid_after", 32'(mem_wvalid), 32'd0);
        rand_ready = 1'b1;
        drain();

        // No destinations, flags only
        t = blank(); t.fwe = 1'b1; t.efl = 32'h0000_0001;
        send(t);
        @(negedge clk); #2;
        check("nd_retire", 32'(retire), 32'd1);
        check("nd_rf_we", 32'(rf_we), 32'd0);
        check("nd_mem_wvalid", 32'(mem_wvalid), 32'd0);
        @(negedge clk); #2;
        check("nd_eflags", eflags_q, 32'h0000_0003);

        // Reserved kind in slot 0, memory write in slot 1
        t = blank(); t.k0 = 2'd3; t.r0 = 3'd2; t.k1 = 2'd2; t.a1 = 32'h0000_2000;
        t.d1 = 32'h1234_5678; t.fwe = 1'b1; t.efl = 32'h0000_0880;
        send(t);
        @(negedge clk); #2;
        check("rsv_wb_err", 32'(wb_err), 32'd1);
        check("rsv_rf_we", 32'(rf_we), 32'd0);
        drain();

        // Reset in the middle of a stalled memory write
        rand_ready = 1'b0; mem_wready = 1'b0;
        t = blank(); t.k0 = 2'd2; t.a0 = 32'h0000_3000; t.d0 = 32'hCAFE_F00D;
        send(t);
        @(negedge clk); #2;
        check("rm_wvalid_before", 32'(mem_wvalid), 32'd1);
        rst = 1'b1;
        exp_err = 1'b0; model_eflags = 32'h2; exp_cnt = 32'd0;
        #1;
        check("rm_wvalid", 32'(mem_wvalid), 32'd0);
        check("rm_in_ready", 32'(in_ready), 32'd1);
        check("rm_eflags", eflags_q, 32'h2);
        check("rm_wb_err", 32'(wb_err), 32'd0);
        check("rm_retire_count", retire_count, 32'd0);
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        rand_ready = 1'b1;

        // Randomized results against the reference model
        for (int n = 0; n < 150; n++) begin
            t.k0 = 2'($urandom_range(0, 3)); t.k1 = 2'($urandom_range(0, 3));
            t.r0 = 3'($urandom_range(0, 7)); t.r1 = 3'($urandom_range(0, 7));
            t.size = 2'($urandom_range(0, 3));
            t.a0 = $urandom; t.a1 = $urandom; t.d0 = $urandom; t.d1 = $urandom;
            t.efl = $urandom; t.fwe = 1'($urandom_range(0, 1));
            send(t);
        end
        drain();

`ifdef WRITEBACK_RETIRE_COUNT_EN
        // Counter wrap
        @(negedge clk); #2;
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        exp_cnt = 32'hFFFF_FFFF;
        #1 release dut.retire_cnt_q;
        t = blank();
        send(t);
        @(negedge clk); @(negedge clk); #2;
        check("cnt_wrap", retire_count, 32'd0);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- Commit stage that consumes the execute stage's results (opnd0_w, opnd1_w, o_eflags) and retires them to architectural state.
- Serializes up to two operand writes, opnd0 then opnd1, onto one register-file write port and one handshaked memory write port.
- Holds the architectural EFLAGS register.
- Sits directly downstream of execute. Its eflags_q output feeds execute's eflags input.

Parameters:
- EFLAGS_RESET, 32'h0000_0002, reset value of the EFLAGS register (reserved bit 1 set).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  execute result valid
- in_ready  output  1  writeback can accept a result
- opnd0_w  input  32  result for destination 0
- opnd1_w  input  32  result for destination 1
- exe_eflags  input  32  prospective EFLAGS from execute
- flags_we  input  1  commit exe_eflags at retire
- dst0_kind  input  2  0 none, 1 reg, 2 mem, 3 reserved
- dst1_kind  input  2  same encoding, destination 1
- dst0_reg  input  3  GPR index for destination 0
- dst1_reg  input  3  GPR index for destination 1
- dst0_addr  input  32  memory address for destination 0
- dst1_addr  input  32  memory address for destination 1
- opnd_size  input  2  0 = 8-bit, 1 = 16-bit, 2 = 32-bit (3 is treated as 32-bit)
- rf_we  output  1  register write strobe
- rf_idx  output  3  register index
- rf_data  output  32  register write data
- rf_bmask  output  4  register byte enables
- mem_wvalid  output  1  memory write request
- mem_wready  input  1  memory accepts the write
- mem_addr  output  32  memory write address
- mem_wdata  output  32  memory write data
- mem_wmask  output  4  memory byte enables
- eflags_q  output  32  architectural EFLAGS
- retire  output  1  one-cycle pulse when an instruction fully commits
- wb_err  output  1  sticky flag: reserved destination kind seen
- retire_count  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset values:
  - FSM in IDLE, in_ready=1.
  - rf_we=0, mem_wvalid=0, retire=0, wb_err=0, retire_count=0.
  - eflags_q=EFLAGS_RESET.
  - All data, address and mask outputs are 0.
- FSM states: IDLE, WB0, WB1, RETIRE. in_ready=1 only in IDLE.
- Accept:
  - Occurs when in_valid && in_ready at a rising edge.
  - Latch all inputs.
  - Next state is WB0 if dst0_kind is reg/mem; else WB1 if dst1_kind is reg/mem; else RETIRE.
  - Slots with kind none or reserved are skipped and take zero cycles.
- Register slot (one cycle):
  - rf_we=1 for exactly that cycle.
  - 32-bit: rf_bmask=1111, data unshifted.
  - 16-bit: rf_bmask=0011, data unshifted.
  - 8-bit, idx 0-3: rf_bmask=0001, rf_idx=idx, data unshifted.
  - 8-bit, idx 4-7 (AH/CH/DH/BH): rf_idx=idx-4, rf_bmask=0010, rf_data = result[7:0] placed in bits 15:8.
- Memory slot:
  - mem_wvalid=1 with addr, data and mask held stable until the cycle mem_wready=1; the slot completes on that edge.
  - mem_wmask: 0001 (8-bit), 0011 (16-bit), 1111 (32-bit). Data is unshifted.
  - mem_wready while mem_wvalid=0 is ignored.
- WB0 exits to WB1 or RETIRE per the latched dst1_kind. WB1 exits to RETIRE.
- RETIRE (one cycle):
  - retire=1.
  - If latched flags_we: eflags_q <= latched exe_eflags, with bit 1 forced to 1.
  - Next state is IDLE.
- Minimum latency:
  - Two register writes: accept at T, WB0 at T+1, WB1 at T+2, retire at T+3, in_ready again at T+4.
  - No destinations: retire at T+1.
- Same register in both slots (e.g. XCHG with identical operands): opnd0 is written first, then opnd1, so the opnd1 value wins.
- Reserved kind (3) in either slot: that slot is skipped and wb_err is set. wb_err is cleared only by rst.
- EFLAGS is never written before RETIRE. Flags from a partially committed instruction are never visible.
- Reset mid-operation: the FSM returns to IDLE immediately and mem_wvalid drops asynchronously. Writes already committed are not undone, and eflags_q returns to EFLAGS_RESET.

Optional Feature:
- Macro: WRITEBACK_RETIRE_COUNT_EN.
- Defined: retire_count increments by 1 on every retire pulse and wraps from 32'hFFFF_FFFF to 0. It is reset to 0.
- Undefined: retire_count is tied to 0 and no counter is built.

Test Plan:
- Register/register commit:
  - Stimulus: dst0 = reg 0, dst1 = reg 3, size 32, opnd0_w=32'h1111_1111, opnd1_w=32'h2222_2222, flags_we=1, exe_eflags=32'h0000_0845.
  - Required: rf writes (0, 1111_1111, 1111) then (3, 2222_2222, 1111) on consecutive cycles; retire at T+3; eflags_q=32'h0000_0847.
- High-byte write:
  - Stimulus: dst0 = reg 4 (AH), size 8, opnd0_w=32'h0000_00AB.
  - Required: rf_idx=0, rf_bmask=0010, rf_data=32'h0000_AB00.
- Memory backpressure:
  - Stimulus: dst0 = mem at 32'h0000_1000, size 16, opnd0_w=32'hBEEF, mem_wready held low for 3 cycles.
  - Required: mem_wvalid, addr, data and mask=0011 stay stable for 4 cycles; retire the cycle after the handshake; in_ready=0 throughout.
- No destinations, flags only:
  - Stimulus: dst0_kind=dst1_kind=0, flags_we=1, exe_eflags=32'h0000_0001.
  - Required: retire at T+1, eflags_q=32'h0000_0003, no rf_we or mem_wvalid.
- Reserved kind, then reset mid-write:
  - Stimulus: dst0_kind=3, dst1 = mem.
  - Required: wb_err=1 and only the memory write occurs.
  - Stimulus: assert rst while mem_wvalid=1.
  - Required: mem_wvalid drops, in_ready=1, eflags_q=32'h0000_0002, wb_err=0.
- Counter wrap (macro defined):
  - Stimulus: force retire_count to 32'hFFFF_FFFF, then retire one instruction.
  - Required: retire_count=0.
